// File: rtl/cust_rom_reader.sv
// Burst read initiator for the cust_rom table ROM: issues credit-checked reads into a ROM_LAT pipeline and streams words out with valid/ready.
// First word is valid 1+ROM_LAT edges after start; m_ready low stalls issue via credits. Optional checksum: CUST_ROM_READER_SUM_EN.
module cust_rom_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_cs0,
  output logic [ADDR_WIDTH-1:0] rom_addr0,
  input  logic [DATA_WIDTH-1:0] rom_dout0,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [DATA_WIDTH-1:0] sum
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] hold_q, hold_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  done_q, done_d;
  logic [ROM_LAT-1:0]    tag_vld_q, tag_vld_d;
  logic [ROM_LAT-1:0]    tag_last_q, tag_last_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] lst_q, lst_d;
  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]           fifo_count;
  logic [PW:0]           inflight;
  logic                  issue;
  logic                  credit_ok;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  fifo_full;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign fifo_wr    = tag_vld_q[ROM_LAT-1];
  assign m_valid    = (fifo_count != '0);
  assign fifo_rd    = m_valid && m_ready;
  assign m_data     = mem_q[rd_ptr_q[PW-1:0]];
  assign m_last     = lst_q[rd_ptr_q[PW-1:0]];

  // Reads already in the ROM pipeline hold a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + {{PW{1'b0}}, tag_vld_q[i]};
    end
  end

  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (PW+2)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = start_addr;
            rem_d   = len;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if ((rem_q != '0) && credit_ok) begin
          issue  = 1'b1;
          hold_d = addr_q;
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
          if (rem_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_rd && m_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign rom_cs0   = busy;
  assign done      = done_q;
  assign rom_addr0 = issue ? addr_q : hold_q;

  always_comb begin
    tag_vld_d     = '0;
    tag_last_d    = '0;
    tag_vld_d[0]  = issue;
    tag_last_d[0] = issue && (rem_q == (ADDR_WIDTH+1)'(1));
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    lst_d    = lst_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q[PW-1:0]] = rom_dout0;
      lst_d[wr_ptr_q[PW-1:0]] = tag_last_q[ROM_LAT-1];
      wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      hold_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      lst_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hold_q     <= hold_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
      lst_q      <= lst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

`ifdef CUST_ROM_READER_SUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if ((state_q == IDLE) && start) begin
      sum_d = '0;
    end else if (fifo_rd) begin
      sum_d = sum_q + m_data;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif

  a_no_fifo_overflow: assert property (@(posedge clk0) disable iff (rst0) !(fifo_wr && fifo_full));

endmodule

// File: tb/tb_cust_rom_reader.sv
// Scoreboard bench for cust_rom_reader: a 3-stage ROM model feeds the DUT, expected words are queued at command time.
module tb_cust_rom_reader;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy, done, rom_cs0;
  logic [AW-1:0] rom_addr0;
  logic [DW-1:0] rom_dout0;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data, sum;

  always #5 clk0 = ~clk0;

  cust_rom_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LAT(3), .FIFO_DEPTH(DEPTH)) dut (
    .clk0(clk0), .rst0(rst0), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .rom_cs0(rom_cs0), .rom_addr0(rom_addr0), .rom_dout0(rom_dout0),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .sum(sum)
  );

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] p1, p2;

  initial begin
    p1 = '0;
    p2 = '0;
    rom_dout0 = '0;
  end

  always @(posedge clk0) begin
    if (rom_cs0) p1 <= mem[rom_addr0];
    p2        <= p1;
    rom_dout0 <= p2;
  end

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_dat_q [$];
  logic          exp_lst_q [$];
  int            ready_mode = 0;
  int            rdy_cyc = 0;
  bit            last_hs = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk0) begin
    #1;
    rdy_cyc++;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = (rdy_cyc >= 8 && rdy_cyc < 18) ? 1'b0 : 1'($urandom_range(0, 1));
    endcase
  end

  // Every visible word must match the queue head, so a stalled word must also hold steady.
  always @(negedge clk0) begin
    if (last_hs) begin
      chk("done_after_last", 64'(done), 64'd1);
      last_hs = 1'b0;
    end
    if (!rst0 && busy)
      chk("credit_bound", 64'((int'(dut.fifo_count) + int'(dut.inflight)) <= DEPTH), 64'd1);
    if (m_valid) begin
      if (exp_dat_q.size() == 0) begin
        chk("unexpected_valid", 64'(m_valid), 64'd0);
      end else begin
        chk("m_data", 64'(m_data), 64'(exp_dat_q[0]));
        chk("m_last", 64'(m_last), 64'(exp_lst_q[0]));
        if (m_ready) begin
          if (exp_lst_q[0]) last_hs = 1'b1;
          void'(exp_dat_q.pop_front());
          void'(exp_lst_q.pop_front());
        end
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_busy"},  64'(busy),      64'd0);
    chk({pfx, "_done"},  64'(done),      64'd0);
    chk({pfx, "_cs"},    64'(rom_cs0),   64'd0);
    chk({pfx, "_addr"},  64'(rom_addr0), 64'd0);
    chk({pfx, "_valid"}, 64'(m_valid),   64'd0);
    chk({pfx, "_data"},  64'(m_data),    64'd0);
    chk({pfx, "_last"},  64'(m_last),    64'd0);
    chk({pfx, "_sum"},   64'(sum),       64'd0);
  endtask

  task automatic run_burst(input logic [AW-1:0] a, input int n, input int mode, input bit poke);
    int            cnt;
    logic [DW-1:0] sum_exp;
    logic [DW-1:0] sum_ref;
    sum_exp    = '0;
    ready_mode = mode;
    rdy_cyc    = 0;
    for (int i = 0; i < n; i++) begin
      exp_dat_q.push_back(mem[AW'(int'(a) + i)]);
      exp_lst_q.push_back(i == n - 1);
      sum_exp += mem[AW'(int'(a) + i)];
    end
`ifdef CUST_ROM_READER_SUM_EN
    sum_ref = sum_exp;
`else
    sum_ref = '0;
`endif
    @(posedge clk0); #1;
    start      = 1'b1;
    start_addr = a;
    len        = (AW+1)'(n);
    @(posedge clk0); #1;
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_cs", 64'(rom_cs0), 64'd0);
      chk("zero_busy", 64'(busy), 64'd0);
      @(posedge clk0); #1;
      chk("zero_done_clear", 64'(done), 64'd0);
      chk("zero_cs_later", 64'(rom_cs0), 64'd0);
      chk("zero_sum", 64'(sum), 64'(sum_ref));
    end else begin
      cnt = 0;
      while (!m_valid && cnt < 50) begin
        @(posedge clk0); #1;
        cnt++;
      end
      chk("first_valid_latency", 64'(cnt), 64'd4);
      cnt = 0;
      while (!done && cnt < 3000) begin
        @(posedge clk0); #1;
        start      = poke && (cnt == 2);
        start_addr = a ^ AW'(5);
        cnt++;
      end
      start = 1'b0;
      chk("done_seen", 64'(done), 64'd1);
      chk("idle_at_done", 64'(busy), 64'd0);
      chk("queue_drained", 64'(exp_dat_q.size()), 64'd0);
      chk("sum_at_done", 64'(sum), 64'(sum_ref));
      @(posedge clk0); #1;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("sum_held", 64'(sum), 64'(sum_ref));
    end
  endtask

  initial begin
    rst0       = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    m_ready    = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0001);
    mem[0] = 32'd1;
    mem[1] = 32'd2;
    mem[2] = 32'd3;
    mem[3] = 32'hFFFF_FFFF;

    repeat (2) @(posedge clk0);
    #1;
    check_all_zero("reset");
    rst0 = 1'b0;

    // Abort a burst with two reads in the ROM pipeline.
    ready_mode = 0;
    @(posedge clk0); #1;
    start      = 1'b1;
    start_addr = 10'h200;
    len        = 11'd8;
    @(posedge clk0); #1;
    start = 1'b0;
    @(posedge clk0); #1;
    @(posedge clk0); #1;
    chk("pre_reset_inflight", 64'(dut.inflight), 64'd2);
    rst0 = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk0); #1;
    rst0 = 1'b0;

    run_burst(10'h010, 8, 0, 1'b0);
    run_burst(10'h3FE, 4, 0, 1'b0);
    run_burst(10'h000, 0, 0, 1'b0);
    run_burst(10'h100, 16, 2, 1'b0);
    run_burst(10'h000, 4, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_burst(AW'($urandom_range(0, 1023)), $urandom_range(1, 20), 1, k == 0);

    repeat (4) @(posedge clk0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
